// File: rtl/ct_ifu_spsram_arb_pkg.sv
// ==========================================================================
// ct_ifu_spsram_arb_pkg : shared types and constants for the IFU SPSRAM arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none

package ct_ifu_spsram_arb_pkg;

  localparam int ADDR_WIDTH      = 8;
  localparam int DATA_WIDTH      = 23;
  localparam int STARVE_MAX_DFLT = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } arb_state_e;

  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ct_ifu_spsram_arb_if.sv
// ==========================================================================
// ct_ifu_spsram_arb_if : requester + SRAM port bundle for ct_ifu_spsram_arb
// Rev 1.0
// ==========================================================================
`default_nettype none

interface ct_ifu_spsram_arb_if import ct_ifu_spsram_arb_pkg::*; ();

  logic                  flush_req;
  logic                  init_busy;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_gnt;
  logic                  rd_data_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_rdy;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  flush_req, rd_req, rd_idx, wr_req, wr_idx, wr_data, wr_mask, sram_q,
    output init_busy, rd_gnt, rd_data_vld, rd_data, wr_rdy,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

  modport master (
    output flush_req, rd_req, rd_idx, wr_req, wr_idx, wr_data, wr_mask, sram_q,
    input  init_busy, rd_gnt, rd_data_vld, rd_data, wr_rdy,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

endinterface

`default_nettype wire

// File: rtl/ct_ifu_spsram_wbuf.sv
// ==========================================================================
// ct_ifu_spsram_wbuf : 1-entry write buffer, starve counter, read bypass
// Rev 1.0   (bypass merge under CT_IFU_SPSRAM_ARB_BYPASS_EN)
// ==========================================================================
`default_nettype none

module ct_ifu_spsram_wbuf import ct_ifu_spsram_arb_pkg::*; #(
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int DATA_W     = DATA_WIDTH,
  parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              capture_i,
  input  logic              drain_i,
  input  logic [ADDR_W-1:0] cap_idx_i,
  input  logic [DATA_W-1:0] cap_data_i,
  input  logic [DATA_W-1:0] cap_mask_i,
  input  logic              rd_gnt_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  input  logic [DATA_W-1:0] sram_q_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] mask_o,
  output logic              starved_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int              SW         = starve_cnt_w(STARVE_MAX);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  logic              vld_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mask_q;
  logic [SW-1:0]     starve_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || drain_i) begin
      vld_q <= 1'b0;
    end else if (capture_i) begin
      vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture_i) begin
      idx_q  <= cap_idx_i;
      data_q <= cap_data_i;
      mask_q <= cap_mask_i;
    end
  end

  // Counts cycles a valid entry loses the port; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || drain_i) begin
      starve_q <= '0;
    end else if (vld_q && (starve_q != STARVE_LIM)) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  assign vld_o     = vld_q;
  assign idx_o     = idx_q;
  assign data_o    = data_q;
  assign mask_o    = mask_q;
  assign starved_o = vld_q && (starve_q == STARVE_LIM);

`ifdef CT_IFU_SPSRAM_ARB_BYPASS_EN
  logic              cap_hit;
  logic              buf_hit;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] byp_mask_q;

  // A write captured this cycle is newer than anything in the buffer.
  assign cap_hit = capture_i && (cap_idx_i == rd_idx_i);
  assign buf_hit = vld_q && !clear_i && (idx_q == rd_idx_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else if (rd_gnt_i) begin
      byp_mask_q <= cap_hit ? cap_mask_i : (buf_hit ? mask_q : '0);
      byp_data_q <= cap_hit ? cap_data_i : data_q;
    end
  end

  assign rd_data_o = (sram_q_i & ~byp_mask_q) | (byp_data_q & byp_mask_q);
`else
  logic unused_byp;
  assign unused_byp = ^{rd_gnt_i, rd_idx_i};
  assign rd_data_o  = sram_q_i;
`endif

endmodule

`default_nettype wire

// File: rtl/ct_ifu_spsram_arb.sv
// ==========================================================================
// ct_ifu_spsram_arb : IFU 256x23 SPSRAM init sweep + read/write arbiter
// Rev 1.0   (optional read bypass: CT_IFU_SPSRAM_ARB_BYPASS_EN)
// ==========================================================================
`default_nettype none

module ct_ifu_spsram_arb import ct_ifu_spsram_arb_pkg::*; #(
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter int                    STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  ct_ifu_spsram_arb_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = '1;

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rd_data_vld_q;

  logic                  init_busy, rd_gnt, wr_rdy;
  logic                  capture, drain;
  logic                  sram_cen, sram_gwen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_wen, sram_d;

  logic                  buf_vld, buf_starved;
  logic [ADDR_WIDTH-1:0] buf_idx;
  logic [DATA_WIDTH-1:0] buf_data, buf_mask, rd_data;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rd_data_vld_q <= rd_gnt;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_busy  = 1'b0;
    rd_gnt     = 1'b0;
    wr_rdy     = 1'b0;
    capture    = 1'b0;
    drain      = 1'b0;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b0;
    sram_wen   = '0;
    sram_a     = '0;
    sram_d     = '0;
    if (cpurst) begin
      init_busy = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_busy  = 1'b1;
          sram_cen   = 1'b0;
          sram_a     = init_cnt_q;
          sram_d     = INIT_VAL;
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          if (init_cnt_q == INIT_LAST) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          wr_rdy = !buf_vld && !bus.flush_req;
          // A flush drops the pending write, so it is never drained that cycle.
          if (buf_starved && !bus.flush_req) begin
            drain = 1'b1;
          end else if (bus.rd_req) begin
            rd_gnt    = 1'b1;
            sram_cen  = 1'b0;
            sram_gwen = 1'b1;
            sram_wen  = '1;
            sram_a    = bus.rd_idx;
            capture   = bus.wr_req && wr_rdy;
          end else if (buf_vld && !bus.flush_req) begin
            drain = 1'b1;
          end else if (bus.wr_req && wr_rdy) begin
            sram_cen = 1'b0;
            sram_wen = ~bus.wr_mask;
            sram_d   = bus.wr_data;
            sram_a   = bus.wr_idx;
          end
          if (drain) begin
            sram_cen = 1'b0;
            sram_wen = ~buf_mask;
            sram_d   = buf_data;
            sram_a   = buf_idx;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
      if (bus.flush_req) begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    end
  end

  ct_ifu_spsram_wbuf #(
    .ADDR_W     (ADDR_WIDTH),
    .DATA_W     (DATA_WIDTH),
    .STARVE_MAX (STARVE_MAX)
  ) u_wbuf (
    .clk_i      (forever_cpuclk),
    .rst_i      (cpurst),
    .clear_i    (bus.flush_req),
    .capture_i  (capture),
    .drain_i    (drain),
    .cap_idx_i  (bus.wr_idx),
    .cap_data_i (bus.wr_data),
    .cap_mask_i (bus.wr_mask),
    .rd_gnt_i   (rd_gnt),
    .rd_idx_i   (bus.rd_idx),
    .sram_q_i   (bus.sram_q),
    .vld_o      (buf_vld),
    .idx_o      (buf_idx),
    .data_o     (buf_data),
    .mask_o     (buf_mask),
    .starved_o  (buf_starved),
    .rd_data_o  (rd_data)
  );

  assign bus.init_busy   = init_busy;
  assign bus.rd_gnt      = rd_gnt;
  assign bus.wr_rdy      = wr_rdy;
  assign bus.rd_data_vld = rd_data_vld_q;
  assign bus.rd_data     = rd_data;
  assign bus.sram_cen    = sram_cen;
  assign bus.sram_gwen   = sram_gwen;
  assign bus.sram_wen    = sram_wen;
  assign bus.sram_a      = sram_a;
  assign bus.sram_d      = sram_d;

endmodule

`default_nettype wire

// File: tb/tb_ct_ifu_spsram_arb.sv
// ==========================================================================
// tb_ct_ifu_spsram_arb : directed scoreboard bench for ct_ifu_spsram_arb
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_ct_ifu_spsram_arb;
  import ct_ifu_spsram_arb_pkg::*;

  localparam logic [22:0] INIT_V = 23'h000000;
`ifdef CT_IFU_SPSRAM_ARB_BYPASS_EN
  localparam logic [22:0] EXP_BYP = 23'h000FFA;
`else
  localparam logic [22:0] EXP_BYP = 23'h000FF0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_next = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  ct_ifu_spsram_arb_if bus();

  ct_ifu_spsram_arb #(.INIT_VAL(INIT_V), .STARVE_MAX(4)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  // SRAM model: garbage after reset so only the sweep can clear it
  logic [22:0] mem [256];
  logic [22:0] q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 23'h5A5A5A ^ 23'(i);
    end else if (!bus.sram_cen) begin
      if (!bus.sram_gwen)
        mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else
        q <= mem[bus.sram_a];
    end
  end
  assign bus.sram_q = q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic rd, input logic [7:0] ridx, input logic wr,
                     input logic [7:0] widx, input logic [22:0] wd,
                     input logic [22:0] wm, input logic fl);
    @(negedge clk);
    rst           = rst_next;
    bus.rd_req    = rd;
    bus.rd_idx    = ridx;
    bus.wr_req    = wr;
    bus.wr_idx    = widx;
    bus.wr_data   = wd;
    bus.wr_mask   = wm;
    bus.flush_req = fl;
    #2;
  endtask

  task automatic idle();
    drv(1'b0, 8'h00, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
  endtask

  task automatic chk_rd(input string nm, input logic [7:0] a);
    chk(nm, {bus.rd_gnt, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a},
            {1'b1, 1'b0, 1'b1, 23'h7FFFFF, a});
  endtask

  task automatic chk_wr(input string nm, input logic [7:0] a, input logic [22:0] wen,
                        input logic [22:0] d);
    chk(nm, {bus.rd_gnt, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d},
            {1'b0, 1'b0, 1'b0, wen, a, d});
  endtask

  // Requests held high during the sweep must be ignored.
  task automatic sweep(input int n, input int fl_at);
    for (int i = 0; i < n; i++) begin
      drv(1'b1, 8'hAA, 1'b1, 8'hAA, 23'h1, 23'h7FFFFF, i == fl_at);
      chk("init_sweep",
          {bus.init_busy, bus.rd_gnt, bus.wr_rdy, bus.sram_cen, bus.sram_gwen,
           bus.sram_wen, bus.sram_a, bus.sram_d},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 8'(i), INIT_V});
    end
  endtask

  // Scoreboard monitor
  always begin
    @(negedge clk);
    #3;
    if (bus.rd_data_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rd_data: got 0x%0h expected no response", bus.rd_data);
      end else begin
        chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.flush_req = 1'b0;
    bus.rd_req    = 1'b1;
    bus.rd_idx    = 8'h12;
    bus.wr_req    = 1'b1;
    bus.wr_idx    = 8'h12;
    bus.wr_data   = 23'h0;
    bus.wr_mask   = 23'h7FFFFF;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_init_busy",   bus.init_busy,   1);
    chk("rst_sram_cen",    bus.sram_cen,    1);
    chk("rst_rd_gnt",      bus.rd_gnt,      0);
    chk("rst_wr_rdy",      bus.wr_rdy,      0);
    chk("rst_rd_data_vld", bus.rd_data_vld, 0);

    rst_next = 1'b0;
    sweep(256, -1);
    idle();
    chk("post_init_busy",   bus.init_busy, 0);
    chk("post_init_wr_rdy", bus.wr_rdy,    1);
    chk("post_init_cen",    bus.sram_cen,  1);

    // Plain read, direct write, read-back
    drv(1'b1, 8'h12, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    chk_rd("read_12", 8'h12);
    exp_q.push_back(23'h000000);
    drv(1'b0, 8'h00, 1'b1, 8'h34, 23'h7FFFFF, 23'h0000FF, 1'b0);
    chk("direct_wr_rdy", bus.wr_rdy, 1);
    chk_wr("direct_wr_34", 8'h34, 23'h7FFF00, 23'h7FFFFF);
    drv(1'b1, 8'h34, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    chk_rd("read_34", 8'h34);
    exp_q.push_back(23'h0000FF);

    // Preload 0x34 = 0xFF0, then starve a buffered write behind reads
    drv(1'b0, 8'h00, 1'b1, 8'h34, 23'h000FF0, 23'h7FFFFF, 1'b0);
    chk_wr("preload_34", 8'h34, 23'h000000, 23'h000FF0);
    drv(1'b1, 8'h34, 1'b1, 8'h34, 23'h00000A, 23'h00000F, 1'b0);
    chk_rd("starve_T_read", 8'h34);
    chk("starve_T_wr_rdy", bus.wr_rdy, 1);
    exp_q.push_back(EXP_BYP);
    for (int k = 1; k <= 4; k++) begin
      drv(1'b1, 8'h34, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
      chk_rd("starve_read", 8'h34);
      chk("starve_wr_rdy", bus.wr_rdy, 0);
      exp_q.push_back(EXP_BYP);
    end
    drv(1'b1, 8'h34, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    chk_wr("starve_T5_drain", 8'h34, 23'h7FFFF0, 23'h00000A);
    chk("starve_T5_wr_rdy", bus.wr_rdy, 0);
    drv(1'b1, 8'h34, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    chk_rd("starve_T6_read", 8'h34);
    chk("starve_T6_wr_rdy", bus.wr_rdy, 1);
    exp_q.push_back(23'h000FFA);

    // Buffered write drains as soon as no read competes
    drv(1'b1, 8'h12, 1'b1, 8'h56, 23'h000123, 23'h7FFFFF, 1'b0);
    chk_rd("cap56_read", 8'h12);
    exp_q.push_back(23'h000000);
    idle();
    chk_wr("idle_drain_56", 8'h56, 23'h000000, 23'h000123);
    chk("idle_drain_wr_rdy", bus.wr_rdy, 0);
    drv(1'b1, 8'h56, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    chk_rd("read_56", 8'h56);
    exp_q.push_back(23'h000123);

    // Flush with a valid buffer: pending write dropped, sweep restarted mid-way
    drv(1'b1, 8'h12, 1'b1, 8'h77, 23'h000555, 23'h7FFFFF, 1'b0);
    chk_rd("cap77_read", 8'h12);
    exp_q.push_back(23'h000000);
    drv(1'b0, 8'h00, 1'b0, 8'h00, 23'h0, 23'h0, 1'b1);
    chk("flush_no_drain_cen", bus.sram_cen, 1);
    chk("flush_wr_rdy", bus.wr_rdy, 0);
    sweep(8'h81, 8'h80);
    sweep(256, -1);
    idle();
    chk("reinit_busy", bus.init_busy, 0);
    chk("reinit_wr_rdy", bus.wr_rdy, 1);
    drv(1'b1, 8'h77, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    exp_q.push_back(INIT_V);
    drv(1'b1, 8'h34, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    exp_q.push_back(INIT_V);
    drv(1'b1, 8'h56, 1'b0, 8'h00, 23'h0, 23'h0, 1'b0);
    exp_q.push_back(INIT_V);

    // Read granted in an IDLE flush cycle still returns data
    drv(1'b1, 8'h56, 1'b0, 8'h00, 23'h0, 23'h0, 1'b1);
    chk_rd("flush_cycle_read", 8'h56);
    exp_q.push_back(INIT_V);
    sweep(256, -1);
    idle();
    chk("final_init_busy", bus.init_busy, 0);
    repeat (3) idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
